// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding imem request, one-entry holding buffer, IF/ID register.
// Optional performance counters (stallCycles, flushCount) are enabled with `define IF_PERF_CNT_EN.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_n,
   input  logic        flushIfIdExMem,
   input  logic [31:0] branchTarget,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemValid,
   input  logic [31:0] imemRdata,
   output logic [31:0] ifidPc,
   output logic [31:0] ifidInstr,
   output logic        ifidValid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] stallCycles,
   output logic [31:0] flushCount
`endif
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   typedef enum logic [1:0] {
      S_FETCH,
      S_WAIT,
      S_DRAIN
   } state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_reqPc;
   logic            r_bufValid;
   logic [XLEN-1:0] r_bufInstr;
   logic [XLEN-1:0] r_bufPc;
   logic [XLEN-1:0] r_ifidPc;
   logic [XLEN-1:0] r_ifidInstr;
   logic            r_ifidValid;

   logic            w_issue;
   logic            w_rspAccept;

   // A request goes out only from FETCH with an empty buffer, no stall and no redirect.
   always_comb begin
      w_issue     = (r_state == S_FETCH) && !r_bufValid && !flushIfIdExMem && stall_n;
      w_rspAccept = (r_state == S_WAIT) && imemValid;
   end

   assign imemReq   = w_issue && !rst;
   assign imemAddr  = r_pc & ALIGN_MASK;
   assign ifidPc    = r_ifidPc;
   assign ifidInstr = r_ifidInstr;
   assign ifidValid = r_ifidValid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_FETCH;
         r_pc        <= RESET_PC;
         r_reqPc     <= RESET_PC;
         r_bufValid  <= 1'b0;
         r_bufInstr  <= NOP_INSTR;
         r_bufPc     <= RESET_PC;
         r_ifidPc    <= RESET_PC;
         r_ifidInstr <= NOP_INSTR;
         r_ifidValid <= 1'b0;
      end else begin
         unique case (r_state)
            S_FETCH: begin
               if (w_issue) begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A redirect with nothing returned yet must still swallow the in-flight response.
               if (flushIfIdExMem) begin
                  r_state <= imemValid ? S_FETCH : S_DRAIN;
               end else if (imemValid) begin
                  r_state <= S_FETCH;
               end
            end
            S_DRAIN: begin
               if (imemValid) begin
                  r_state <= S_FETCH;
               end
            end
            default: r_state <= S_FETCH;
         endcase

         if (w_issue) begin
            r_reqPc <= r_pc;
            r_pc    <= r_pc + XLEN'(4);
         end

         if (flushIfIdExMem) begin
            r_pc        <= branchTarget & ALIGN_MASK;
            r_bufValid  <= 1'b0;
            r_ifidValid <= 1'b0;
            r_ifidInstr <= NOP_INSTR;
         end else if (stall_n) begin
            if (r_bufValid) begin
               r_ifidPc    <= r_bufPc;
               r_ifidInstr <= r_bufInstr;
               r_ifidValid <= 1'b1;
               r_bufValid  <= 1'b0;
            end else if (w_rspAccept) begin
               r_ifidPc    <= r_reqPc;
               r_ifidInstr <= imemRdata;
               r_ifidValid <= 1'b1;
            end else begin
               r_ifidValid <= 1'b0;
               r_ifidInstr <= NOP_INSTR;
            end
         end else if (w_rspAccept) begin
            // IF/ID is frozen; park the response until the stall lifts.
            r_bufValid <= 1'b1;
            r_bufInstr <= imemRdata;
            r_bufPc    <= r_reqPc;
         end
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [XLEN-1:0] r_stallCycles;
   logic [XLEN-1:0] r_flushCount;

   // A flush cycle is counted as a flush even if stall_n is also low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stallCycles <= '0;
         r_flushCount  <= '0;
      end else if (flushIfIdExMem) begin
         r_flushCount <= r_flushCount + XLEN'(1);
      end else if (!stall_n) begin
         r_stallCycles <= r_stallCycles + XLEN'(1);
      end
   end

   assign stallCycles = r_stallCycles;
   assign flushCount  = r_flushCount;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: memory/stimulus driver pushes expected deliveries, a monitor checks them.
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_n;
   logic        flushIfIdExMem;
   logic [31:0] branchTarget;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemValid;
   logic [31:0] imemRdata;
   logic [31:0] ifidPc;
   logic [31:0] ifidInstr;
   logic        ifidValid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] stallCycles;
   logic [31:0] flushCount;
`endif

   if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall_n        (stall_n),
      .flushIfIdExMem (flushIfIdExMem),
      .branchTarget   (branchTarget),
      .imemReq        (imemReq),
      .imemAddr       (imemAddr),
      .imemValid      (imemValid),
      .imemRdata      (imemRdata),
      .ifidPc         (ifidPc),
      .ifidInstr      (ifidInstr),
      .ifidValid      (ifidValid)
`ifdef IF_PERF_CNT_EN
      ,
      .stallCycles    (stallCycles),
      .flushCount     (flushCount)
`endif
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] addr;
      int          ep;
      bit          abandoned;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } item_t;

   mreq_t       mq[$];
   item_t       exp_q[$];
   int          cyc = 0;
   int          epoch = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          req_seen = 1'b0;
   logic [31:0] req_addr = '0;
   bit          tp_mode = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A17};
   endfunction

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock of stimulus: inputs change on the falling edge and are consumed on the next rising edge.
   task automatic cycle(input bit r, input bit st, input bit fl, input logic [31:0] tg);
      mreq_t m;
      item_t it;
      @(negedge clk);
      cyc++;
      rst            = r;
      stall_n        = !st;
      flushIfIdExMem = fl;
      branchTarget   = tg;
      imemValid      = 1'b0;
      imemRdata      = $urandom();
      if (r) begin
         foreach (mq[k]) mq[k].abandoned = 1'b1;
         exp_q.delete();
         epoch++;
      end else if (mq.size() > 0 && (mq[0].abandoned || mq[0].due <= cyc)) begin
         m = mq.pop_front();
         imemValid = 1'b1;
         if (m.abandoned || m.ep != epoch) begin
            imemRdata = ~instr_of(m.addr);
         end else begin
            imemRdata = instr_of(m.addr);
            if (!fl) begin
               it.pc    = m.addr;
               it.instr = imemRdata;
               exp_q.push_back(it);
            end
         end
      end
      if (fl && !r) begin
         exp_q.delete();
         epoch++;
      end
      #1;
      req_seen = imemReq;
      req_addr = imemAddr;
      if (imemReq && !r) begin
         m.due       = cyc + int'($urandom_range(lat_max, lat_min));
         m.addr      = imemAddr;
         m.ep        = epoch;
         m.abandoned = 1'b0;
         mq.push_back(m);
      end
   endtask

   task automatic do_reset(input int n);
      repeat (n) cycle(1'b1, 1'b0, 1'b0, 32'h0);
   endtask

   // Monitor: program-order model of fetch addresses and IF/ID contents.
   initial begin
      logic [31:0] nreq;
      bit          busy;
      logic        pv;
      logic [31:0] pi;
      logic [31:0] pp;
      int          since;
      int          last;
      item_t       e;
      int          scnt;
      int          fcnt;
      nreq = RESET_PC; busy = 1'b0; pv = 1'b0; pi = NOP; pp = RESET_PC;
      since = 0; last = -1; scnt = 0; fcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (req_seen) begin
            chk(!rst && !flushIfIdExMem && stall_n && !busy, "req_legal", req_addr, nreq);
            chk(req_addr == nreq, "req_addr", req_addr, nreq);
            nreq = nreq + 32'd4;
         end
         if (rst) begin
            busy = 1'b0;
            nreq = RESET_PC;
         end else begin
            if (imemValid) busy = 1'b0;
            if (req_seen) busy = 1'b1;
            if (flushIfIdExMem) nreq = branchTarget & ~32'h3;
         end

         if (rst) begin
            since = 0;
            last  = -1;
         end else begin
            since++;
         end

         if (rst) begin
            chk(!ifidValid, "rst_valid", 32'(ifidValid), 32'd0);
            chk(ifidInstr == NOP, "rst_instr", ifidInstr, NOP);
            chk(ifidPc == RESET_PC, "rst_pc", ifidPc, RESET_PC);
         end else if (flushIfIdExMem) begin
            chk(!ifidValid && ifidInstr == NOP, "flush_bubble", ifidInstr, NOP);
            chk(ifidPc == pp, "flush_pc_hold", ifidPc, pp);
         end else if (!stall_n) begin
            chk(ifidValid == pv && ifidInstr == pi, "stall_hold_instr", ifidInstr, pi);
            chk(ifidPc == pp, "stall_hold_pc", ifidPc, pp);
         end else if (ifidValid) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_valid", ifidPc, 32'h0);
            end else begin
               e = exp_q.pop_front();
               chk(ifidPc == e.pc, "ifid_pc", ifidPc, e.pc);
               chk(ifidInstr == e.instr, "ifid_instr", ifidInstr, e.instr);
            end
            if (tp_mode) begin
               if (last < 0) chk(since == 2, "first_latency", 32'(since), 32'd2);
               else chk(since - last == 2, "throughput_gap", 32'(since - last), 32'd2);
               last = since;
            end
         end else begin
            chk(ifidInstr == NOP && ifidPc == pp, "bubble", ifidInstr, NOP);
         end

`ifdef IF_PERF_CNT_EN
         if (rst) begin
            scnt = 0;
            fcnt = 0;
         end else if (flushIfIdExMem) begin
            fcnt++;
         end else if (!stall_n) begin
            scnt++;
         end
         chk(stallCycles == 32'(scnt), "stallCycles", stallCycles, 32'(scnt));
         chk(flushCount == 32'(fcnt), "flushCount", flushCount, 32'(fcnt));
`endif
         pv = ifidValid;
         pi = ifidInstr;
         pp = ifidPc;
      end
   end

   initial begin
      rst = 1'b1; stall_n = 1'b1; flushIfIdExMem = 1'b0; branchTarget = '0;
      imemValid = 1'b0; imemRdata = '0;

      // Straight-line fetch, 1-cycle memory: one instruction every two cycles.
      lat_min = 1; lat_max = 1;
      do_reset(2);
      tp_mode = 1'b1;
      repeat (21) cycle(1'b0, 1'b0, 1'b0, 32'h0);
      tp_mode = 1'b0;

      // Stall while the 0x4 response returns: it parks in the buffer.
      do_reset(2);
      for (int k = 1; k <= 14; k++) cycle(1'b0, (k >= 4 && k <= 6), 1'b0, 32'h0);

      // Flush together with stall while the buffer is full.
      do_reset(2);
      for (int k = 1; k <= 10; k++) cycle(1'b0, (k == 4 || k == 5), (k == 5), 32'h0000_0202);

      // Flush during WAIT with 3-cycle memory: stale response must be drained.
      lat_min = 3; lat_max = 3;
      do_reset(2);
      for (int k = 1; k <= 16; k++) cycle(1'b0, 1'b0, (k == 6), 32'h0000_0103);

      // Reset in WAIT; the abandoned response returns on the first cycle out of reset.
      do_reset(2);
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      do_reset(2);
      repeat (10) cycle(1'b0, 1'b0, 1'b0, 32'h0);

      // Counter scenario: five stall cycles and two flush cycles.
      lat_min = 1; lat_max = 1;
      do_reset(2);
      for (int k = 1; k <= 12; k++)
         cycle(1'b0, (k == 2 || k == 3 || k == 5 || k == 6 || k == 9), (k == 4 || k == 10), 32'h0000_0040);

      // Random traffic with variable latency, stalls, redirects and the odd reset.
      lat_min = 1; lat_max = 3;
      do_reset(2);
      repeat (2000) begin
         cycle(($urandom_range(199, 0) == 0),
               ($urandom_range(99, 0) < 25),
               ($urandom_range(99, 0) < 6),
               $urandom());
      end

      @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, is the bubble encoding (addi x0,x0,0).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 stall_n  in  1  low = hold PC and IF/ID (from hazard detection unit).
REQ-006 flushIfIdExMem  in  1  high = redirect to branchTarget and kill the fetched instruction.
REQ-007 branchTarget  in  32  redirect address, valid with flushIfIdExMem.
REQ-008 imemReq  out  1  instruction-memory request strobe, accepted the same cycle.
REQ-009 imemAddr  out  32  request address, word aligned.
REQ-010 imemValid  in  1  response strobe, at least 1 cycle after request.
REQ-011 imemRdata  in  32  instruction, valid with imemValid.
REQ-012 ifidPc, ifidInstr  out  32 each  IF/ID register contents.
REQ-013 ifidValid  out  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-014 At most one outstanding imem request at any time.
REQ-015 FSM states: FETCH, WAIT, DRAIN; one-entry holding buffer (bufValid, bufInstr, bufPc).
REQ-016 FETCH, bufValid=0, no flush: imemReq=1, imemAddr=pc; reqPc<=pc, pc<=pc+4 (mod 2^32); next WAIT.
REQ-017 FETCH with bufValid=1: imemReq=0; stay FETCH until the buffer drains.
REQ-018 WAIT: imemReq=0; on imemValid go to FETCH; otherwise stay in WAIT.
REQ-019 IF/ID load source when stall_n=1, in priority order:
- buffer, if bufValid;
- else imem response this cycle;
- else bubble (ifidValid=0, ifidInstr=NOP_INSTR, ifidPc unchanged).
REQ-020 A response arriving while stall_n=0 is written to the buffer with reqPc; IF/ID holds.
REQ-021 When stall_n=0, PC, IF/ID and buffer hold, except as REQ-020 and REQ-022 require.
REQ-022 flushIfIdExMem=1 takes priority over stall_n and all loads:
- IF/ID becomes a bubble;
- bufValid<=0;
- pc<=branchTarget with bits [1:0] forced to 0.
REQ-023 Flush in WAIT without imemValid the same cycle: next state DRAIN; otherwise next state FETCH.
REQ-024 DRAIN: imemReq=0; the next imemValid is discarded, then the FSM goes to FETCH.
REQ-025 Flush in FETCH suppresses that cycle's request (imemReq=0); the first request goes to the target next cycle.
REQ-026 imemValid in FETCH is ignored; this covers stale responses after reset.
REQ-027 Steady-state throughput with 1-cycle memory latency is one instruction per 2 cycles.

Reset
REQ-028 rst forces, asynchronously:
- FSM state FETCH, pc=RESET_PC, reqPc=RESET_PC;
- bufValid=0, bufInstr=NOP_INSTR;
- ifidValid=0, ifidInstr=NOP_INSTR, ifidPc=RESET_PC;
- imemReq=0 while rst is high.
REQ-029 Reset mid-WAIT or mid-DRAIN abandons the outstanding request; the late response is dropped per REQ-026.

Configuration
REQ-030 Macro IF_PERF_CNT_EN, when defined, adds two ports:
- stallCycles  out  32  counts cycles with stall_n=0 and flushIfIdExMem=0;
- flushCount  out  32  counts cycles with flushIfIdExMem=1.
REQ-031 Both counters wrap modulo 2^32 and reset to 0.
REQ-032 Without IF_PERF_CNT_EN, the counter ports and logic are absent and the block's behaviour is otherwise identical.

Verification
REQ-033 Reset, memory latency 1, no stall: imemAddr sequence 0x0,0x4,0x8; ifidPc 0x0,0x4,0x8 with ifidValid=1 every other cycle.
REQ-034 stall_n=0 for 3 cycles as response for 0x4 arrives: IF/ID holds 0x0 instruction, buffer captures 0x4, no new imemReq; 0x4 enters IF/ID the first cycle stall_n=1.
REQ-035 flushIfIdExMem=1 with branchTarget=0x103 during WAIT, memory latency 3: DRAIN entered, the stale response is discarded, next imemAddr=0x100, ifidValid=0 until the 0x100 instruction arrives.
REQ-036 Flush and stall_n=0 in the same cycle with bufValid=1: buffer cleared, IF/ID bubble, pc=target.
REQ-037 rst asserted in WAIT, response arrives 1 cycle after rst falls: response ignored, first imemAddr=RESET_PC.
REQ-038 With IF_PERF_CNT_EN defined, 5 stall cycles and 2 flush cycles: stallCycles=5, flushCount=2.
